sfp_acc: RTL and testbench
==========================

SFP_ACC -- requirements
Module: sfp_acc

Interface
REQ-001 The block SHALL use parameter col, default 8: number of output columns (lanes) read from the output FIFO.
REQ-002 The block SHALL use parameter psum_bw, default 16: signed partial-sum width per column.
REQ-003 The block SHALL use parameter acc_bw, default 22: signed accumulator width per column (psum_bw+6).
REQ-004 The block SHALL have port clk  input  1  the single clock; all state updates on its rising edge.
REQ-005 The block SHALL have port reset  input  1  asynchronous, active-low reset: reset=0 asserts, reset=1 releases.
REQ-006 The block SHALL have port start  input  1  begin one accumulation job; sampled only in IDLE.
REQ-007 The block SHALL have port num_acc  input  6  number of vectors K to accumulate, 1..63; 0 is treated as 1.
REQ-008 The block SHALL have port relu_en  input  1  apply ReLU to the result; latched with start.
REQ-009 The block SHALL have port ofifo_valid  input  1  output FIFO holds at least one full row.
REQ-010 The block SHALL have port ofifo_out  input  col*psum_bw  row data, first-word-fall-through, column 0 in bits [psum_bw-1:0].
REQ-011 The block SHALL have port ofifo_rd  output  1  pop one row from the output FIFO.
REQ-012 The block SHALL have port out  output  col*psum_bw  result row, same lane packing as ofifo_out.
REQ-013 The block SHALL have port out_valid  output  1  out holds a result.
REQ-014 The block SHALL have port out_ready  input  1  downstream accepts out.
REQ-015 The block SHALL have port busy  output  1  high in every state except IDLE.

Function
REQ-016 FSM states SHALL be IDLE, ACC, OUT.
REQ-017 IDLE: on start=1, latch K=max(num_acc,1) and relu_en, clear all accumulators and the count, then enter ACC on the next edge.
REQ-018 ACC: ofifo_rd SHALL equal ofifo_valid (combinational); ofifo_rd SHALL be 0 in IDLE and OUT.
REQ-019 ACC: each cycle with ofifo_rd=1, each lane adds the sign-extended ofifo_out lane to its accumulator and the count increments; ofifo_valid=0 stalls with no state change.
REQ-020 ACC: the K-th read SHALL move to OUT on the same edge; out_valid SHALL rise one cycle after the K-th read.
REQ-021 OUT: each lane result SHALL be the accumulator saturated to signed psum_bw range [-2^(psum_bw-1), 2^(psum_bw-1)-1], then forced to 0 if negative when the latched relu_en=1.
REQ-022 OUT: out and out_valid SHALL be held stable until out_ready=1; on out_valid&out_ready, go to IDLE on that edge.
REQ-023 start SHALL be ignored outside IDLE; num_acc and relu_en changes after the start cycle SHALL have no effect on the current job.
REQ-024 out SHALL be registered; no combinational path from ofifo_out to out.
REQ-025 The accumulator SHALL NOT wrap for K<=63 at any psum values.

Reset
REQ-026 On reset=0, asynchronously: state=IDLE, count=0, accumulators=0, out=0, out_valid=0, busy=0, latched relu_en=0; ofifo_rd=0 throughout.
REQ-027 Reset asserted mid-job SHALL abandon the job; no out_valid SHALL be produced for it after release.
REQ-028 The first start SHALL be honoured in the first cycle after reset release.

Structure
REQ-029 Package sfp_pkg SHALL hold the col/psum_bw/acc_bw defaults and the FSM state type.
REQ-030 One sub-module sfp_lane SHALL implement per-column accumulate, saturate and ReLU, instantiated col times in a generate loop; FSM and count live in sfp_acc.

Verification
REQ-031 K=4, ofifo_valid=1 continuously, all lanes +10 each row, relu_en=0 -> 4 reads on consecutive cycles, out_valid one cycle after the 4th read, every lane=40.
REQ-032 K=3, lane0 rows -100,+20,+30, relu_en=1 -> lane0=0; relu_en=0 -> lane0=-50.
REQ-033 K=63, all lanes 32767 every row -> every lane=32767 (saturated), no wrap; with -32768 rows -> -32768.
REQ-034 K=2, ofifo_valid toggling 1,0,0,1 -> ofifo_rd only in valid cycles, accumulate exactly 2 rows; out_ready held 0 for 5 cycles -> out and out_valid stable, then single handshake returns to IDLE.
REQ-035 start asserted in ACC and OUT -> ignored; num_acc=0 -> one read, out equals that row.
REQ-036 reset=0 after 2 of K=5 reads -> all outputs 0 immediately; after release with no new start, no out_valid and ofifo_rd=0.

Source files
------------

// File: rtl/sfp_pkg.sv
// Shared defaults and FSM state type for the SFP accumulator slice.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package sfp_pkg;

  localparam int SFP_COL     = 8;   // output columns (lanes)
  localparam int SFP_PSUM_BW = 16;  // signed partial-sum width per lane
  localparam int SFP_ACC_BW  = 22;  // psum_bw + 6: holds 63 full-scale rows without wrap
  localparam int SFP_CNT_BW  = 6;   // job length counter, K = 1..63

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_ACC  = 2'd1,
    ST_OUT  = 2'd2
  } sfp_state_t;

endpackage

// File: rtl/sfp_lane.sv
// One column: accumulates sign-extended partial sums, saturates to psum_bw, optional ReLU.
// Latency: result register loads on the edge of the final add (visible the next cycle).
// Backpressure: none internally; the parent holds i_add low and r_out stable while stalled.
//
// Ports:
//   clk, reset      clock, async active-low reset
//   i_clear         zero the accumulator (job start)
//   i_add           add i_psum into the accumulator this edge
//   i_last          this add is the final one of the job: capture the result
//   i_relu          latched ReLU enable for the current job
//   i_psum          signed partial sum for this column
//   o_out           registered saturated (and optionally rectified) result
module sfp_lane #(
  parameter int psum_bw = 16,
  parameter int acc_bw  = 22
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               i_clear,
  input  logic               i_add,
  input  logic               i_last,
  input  logic               i_relu,
  input  logic [psum_bw-1:0] i_psum,
  output logic [psum_bw-1:0] o_out
);

  // Saturation bounds expressed at accumulator width so the compare is a plain signed compare.
  localparam logic signed [acc_bw-1:0] SAT_MAX =
    {{(acc_bw-psum_bw+1){1'b0}}, {(psum_bw-1){1'b1}}};
  localparam logic signed [acc_bw-1:0] SAT_MIN =
    {{(acc_bw-psum_bw+1){1'b1}}, {(psum_bw-1){1'b0}}};

  logic signed [acc_bw-1:0] r_acc;
  logic        [psum_bw-1:0] r_out;
  logic signed [acc_bw-1:0] w_sext;
  logic signed [acc_bw-1:0] w_sum;
  logic        [psum_bw-1:0] w_sat;
  logic        [psum_bw-1:0] w_res;

  assign w_sext = {{(acc_bw-psum_bw){i_psum[psum_bw-1]}}, i_psum};
  assign w_sum  = r_acc + w_sext;

  // The result is taken from the sum that includes the final row, so out_valid
  // can follow the last read by exactly one cycle.
  always_comb begin
    w_sat = w_sum[psum_bw-1:0];
    if (w_sum > SAT_MAX) begin
      w_sat = SAT_MAX[psum_bw-1:0];
    end else if (w_sum < SAT_MIN) begin
      w_sat = SAT_MIN[psum_bw-1:0];
    end
  end

  assign w_res = (i_relu && w_sat[psum_bw-1]) ? '0 : w_sat;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_acc <= '0;
      r_out <= '0;
    end else begin
      if (i_clear) begin
        r_acc <= '0;
      end else if (i_add) begin
        r_acc <= w_sum;
      end
      if (i_add && i_last) begin
        r_out <= w_res;
      end
    end
  end

  assign o_out = r_out;

endmodule

// File: rtl/sfp_acc.sv
// Accumulates K rows from the output FIFO per column, then presents one saturated/ReLU row.
// Latency: out_valid rises one cycle after the K-th FIFO read.
// Backpressure: reads stall while ofifo_valid=0; result held until out_ready handshake.
//
// Ports:
//   clk, reset                 clock, async active-low reset
//   start, num_acc, relu_en    job request (sampled in IDLE only); num_acc=0 means 1
//   ofifo_valid, ofifo_out     FWFT output-FIFO row, column 0 in the low bits
//   ofifo_rd                   pop one row (combinational, ACC state only)
//   out, out_valid, out_ready  registered result row with valid/ready handshake
//   busy                       high whenever a job is in progress
module sfp_acc
  import sfp_pkg::*;
#(
  parameter int col     = SFP_COL,
  parameter int psum_bw = SFP_PSUM_BW,
  parameter int acc_bw  = SFP_ACC_BW
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   start,
  input  logic [5:0]             num_acc,
  input  logic                   relu_en,
  input  logic                   ofifo_valid,
  input  logic [col*psum_bw-1:0] ofifo_out,
  output logic                   ofifo_rd,
  output logic [col*psum_bw-1:0] out,
  output logic                   out_valid,
  input  logic                   out_ready,
  output logic                   busy
);

  sfp_state_t            r_state;
  sfp_state_t            w_state_nxt;
  logic [SFP_CNT_BW-1:0] r_count;
  logic [SFP_CNT_BW-1:0] r_k;
  logic                  r_relu;
  logic                  w_clear;
  logic                  w_last;

  always_comb begin
    w_state_nxt = r_state;
    ofifo_rd    = 1'b0;
    out_valid   = 1'b0;
    busy        = 1'b1;
    w_clear     = 1'b0;
    w_last      = 1'b0;
    unique case (r_state)
      ST_IDLE: begin
        busy = 1'b0;
        if (start) begin
          w_clear     = 1'b1;
          w_state_nxt = ST_ACC;
        end
      end
      ST_ACC: begin
        ofifo_rd = ofifo_valid;
        // r_count holds reads already done, so the K-th read sees K-1 here.
        if (ofifo_valid && (r_count == r_k - 6'd1)) begin
          w_last      = 1'b1;
          w_state_nxt = ST_OUT;
        end
      end
      ST_OUT: begin
        out_valid = 1'b1;
        if (out_ready) begin
          w_state_nxt = ST_IDLE;
        end
      end
      default: begin
        w_state_nxt = ST_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_state <= ST_IDLE;
      r_count <= '0;
      r_k     <= 6'd1;
      r_relu  <= 1'b0;
    end else begin
      r_state <= w_state_nxt;
      if (w_clear) begin
        r_count <= '0;
        r_k     <= (num_acc == 6'd0) ? 6'd1 : num_acc;
        r_relu  <= relu_en;
      end else if (ofifo_rd) begin
        r_count <= r_count + 6'd1;
      end
    end
  end

  for (genvar gi = 0; gi < col; gi++) begin : g_lane
    sfp_lane #(
      .psum_bw (psum_bw),
      .acc_bw  (acc_bw)
    ) u_lane (
      .clk     (clk),
      .reset   (reset),
      .i_clear (w_clear),
      .i_add   (ofifo_rd),
      .i_last  (w_last),
      .i_relu  (r_relu),
      .i_psum  (ofifo_out[gi*psum_bw +: psum_bw]),
      .o_out   (out[gi*psum_bw +: psum_bw])
    );
  end

endmodule

// File: tb/tb_sfp_acc.sv
// Directed bench for sfp_acc with a job-level reference model and per-cycle compare.
// Latency: n/a.
// Backpressure: bench drives ofifo_valid patterns and out_ready holds.
module tb_sfp_acc;

  localparam int COL = 8;
  localparam int PBW = 16;

  logic               clk = 1'b0;
  logic               reset = 1'b0;
  logic               start = 1'b0;
  logic [5:0]         num_acc = 6'd0;
  logic               relu_en = 1'b0;
  logic               ofifo_valid = 1'b0;
  logic [COL*PBW-1:0] ofifo_out = '0;
  logic               ofifo_rd;
  logic [COL*PBW-1:0] out;
  logic               out_valid;
  logic               out_ready = 1'b0;
  logic               busy;

  sfp_acc #(.col(COL), .psum_bw(PBW), .acc_bw(22)) dut (
    .clk         (clk),
    .reset       (reset),
    .start       (start),
    .num_acc     (num_acc),
    .relu_en     (relu_en),
    .ofifo_valid (ofifo_valid),
    .ofifo_out   (ofifo_out),
    .ofifo_rd    (ofifo_rd),
    .out         (out),
    .out_valid   (out_valid),
    .out_ready   (out_ready),
    .busy        (busy)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int failures = 0;
  int rd_cnt = 0;

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  function automatic int lane(input int i);
    logic signed [PBW-1:0] v;
    v = out[i*PBW +: PBW];
    return int'(v);
  endfunction

  // Job-level reference: is a job open, how many reads remain, running sums, final result.
  bit m_busy = 1'b0;
  int m_left = 0;
  bit m_relu = 1'b0;
  int m_sum[COL];
  int m_res[COL];

  always @(posedge clk or negedge reset) begin
    if (!reset) begin
      m_busy = 1'b0;
      m_left = 0;
      m_relu = 1'b0;
    end else if (!m_busy) begin
      if (start) begin
        m_busy = 1'b1;
        m_left = (num_acc == 0) ? 1 : int'(num_acc);
        m_relu = relu_en;
        for (int i = 0; i < COL; i++) m_sum[i] = 0;
      end
    end else if (m_left > 0) begin
      if (ofifo_valid) begin
        for (int i = 0; i < COL; i++) begin
          logic signed [PBW-1:0] p;
          p = ofifo_out[i*PBW +: PBW];
          m_sum[i] += int'(p);
        end
        m_left--;
        if (m_left == 0) begin
          for (int i = 0; i < COL; i++) begin
            int s;
            s = m_sum[i];
            if (s > 32767) s = 32767;
            else if (s < -32768) s = -32768;
            if (m_relu && s < 0) s = 0;
            m_res[i] = s;
          end
        end
      end
    end else if (out_ready) begin
      m_busy = 1'b0;
    end
  end

  // Per-cycle compare against the model, away from the active edge.
  always @(negedge clk) begin
    chk("ofifo_rd", ofifo_rd, (m_busy && m_left > 0 && ofifo_valid) ? 1 : 0);
    chk("busy", busy, m_busy ? 1 : 0);
    chk("out_valid", out_valid, (m_busy && m_left == 0) ? 1 : 0);
    if (m_busy && m_left == 0) begin
      for (int i = 0; i < COL; i++) chk("out_lane", lane(i), m_res[i]);
    end
    if (ofifo_rd) rd_cnt++;
  end

  // Row source: lane0 from q_l0, lane i>0 from q_oth + q_step*i; row index = reads so far.
  int q_l0[$];
  int q_oth[$];
  int q_step = 0;
  bit vpat[$];

  task automatic drive_row(input int r);
    int v;
    for (int i = 0; i < COL; i++) begin
      if (i == 0) v = (r < q_l0.size()) ? q_l0[r] : 0;
      else        v = (r < q_oth.size()) ? q_oth[r] + q_step * i : 0;
      ofifo_out[i*PBW +: PBW] = 16'(v);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Issues start, feeds rows, and returns cycles from the start cycle until out_valid is seen.
  task automatic run_job(input int k_in, input bit relu, input bit hold_start,
                         input int budget, output int ncyc);
    num_acc     = 6'(k_in);
    relu_en     = relu;
    start       = 1'b1;
    rd_cnt      = 0;
    ofifo_valid = 1'b1;
    drive_row(0);
    ncyc = 0;
    do begin
      tick();
      ncyc++;
      start   = hold_start;
      num_acc = 6'd17;
      relu_en = ~relu;
      ofifo_valid = vpat[(ncyc - 1) % vpat.size()];
      drive_row(rd_cnt);
    end while (!out_valid && ncyc < budget);
    chk("job_done_in_budget", out_valid, 1);
  endtask

  task automatic finish_job(input int hold, input int exp0);
    out_ready = 1'b0;
    for (int c = 0; c < hold; c++) begin
      tick();
      chk("hold_valid", out_valid, 1);
      chk("hold_lane0", lane(0), exp0);
    end
    out_ready = 1'b1;
    tick();
    out_ready   = 1'b0;
    start       = 1'b0;
    ofifo_valid = 1'b0;
    chk("idle_after_handshake", busy, 0);
  endtask

  initial begin
    int n;
    #200000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    int n;
    ofifo_valid = 1'b1;
    repeat (3) tick();
    chk("rst_out", lane(0), 0);
    chk("rst_out_valid", out_valid, 0);
    chk("rst_busy", busy, 0);
    chk("rst_ofifo_rd", ofifo_rd, 0);
    reset = 1'b1;

    // K=4, all +10, start in the first cycle after release.
    q_l0 = '{10, 10, 10, 10}; q_oth = '{10, 10, 10, 10}; q_step = 0; vpat = '{1'b1};
    run_job(4, 1'b0, 1'b0, 20, n);
    chk("k4_cycles", n, 5);
    chk("k4_reads", rd_cnt, 4);
    chk("k4_lane0", lane(0), 40);
    chk("k4_lane7", lane(7), 40);
    finish_job(0, 40);

    // K=3, lane0 -100,+20,+30 with and without ReLU.
    q_l0 = '{-100, 20, 30}; q_oth = '{0, 0, 0};
    run_job(3, 1'b1, 1'b0, 20, n);
    chk("relu_lane0", lane(0), 0);
    finish_job(0, 0);
    run_job(3, 1'b0, 1'b0, 20, n);
    chk("norelu_lane0", lane(0), -50);
    finish_job(0, -50);

    // K=63 full-scale rows: saturate, never wrap.
    q_l0.delete(); q_oth.delete();
    for (int r = 0; r < 63; r++) begin q_l0.push_back(32767); q_oth.push_back(32767); end
    run_job(63, 1'b0, 1'b0, 100, n);
    chk("k63_cycles", n, 64);
    chk("sat_pos_lane0", lane(0), 32767);
    chk("sat_pos_lane5", lane(5), 32767);
    finish_job(0, 32767);
    q_l0.delete(); q_oth.delete();
    for (int r = 0; r < 63; r++) begin q_l0.push_back(-32768); q_oth.push_back(-32768); end
    run_job(63, 1'b0, 1'b0, 100, n);
    chk("sat_neg_lane0", lane(0), -32768);
    finish_job(0, -32768);

    // K=2 with valid gaps, then out_ready held low for 5 cycles.
    q_l0 = '{5, 7}; q_oth = '{1, 2}; vpat = '{1'b1, 1'b0, 1'b0, 1'b1};
    run_job(2, 1'b0, 1'b0, 20, n);
    chk("gap_cycles", n, 5);
    chk("gap_reads", rd_cnt, 2);
    chk("gap_lane0", lane(0), 12);
    chk("gap_lane1", lane(1), 3);
    finish_job(5, 12);

    // num_acc=0 acts as 1; start held high through ACC and OUT is ignored.
    q_l0 = '{-1234}; q_oth = '{77}; vpat = '{1'b1};
    run_job(0, 1'b0, 1'b1, 20, n);
    chk("k0_cycles", n, 2);
    chk("k0_lane0", lane(0), -1234);
    chk("k0_lane3", lane(3), 77);
    finish_job(2, -1234);
    chk("k0_reads", rd_cnt, 1);

    // Lane-distinct values with ReLU, to catch lane ordering errors.
    q_l0 = '{3, 4}; q_oth = '{-1000, -1000}; q_step = 300;
    run_job(2, 1'b1, 1'b0, 20, n);
    chk("dist_lane0", lane(0), 7);
    chk("dist_lane3", lane(3), 0);
    chk("dist_lane4", lane(4), 400);
    chk("dist_lane7", lane(7), 2200);
    finish_job(0, 7);
    q_step = 0;

    // Reset after 2 of K=5 reads abandons the job.
    q_l0 = '{9, 9, 9, 9, 9}; q_oth = '{9, 9, 9, 9, 9};
    num_acc = 6'd5; relu_en = 1'b0; start = 1'b1; rd_cnt = 0;
    ofifo_valid = 1'b1; drive_row(0);
    tick(); start = 1'b0; drive_row(rd_cnt);
    tick(); drive_row(rd_cnt);
    tick();
    chk("abort_reads", rd_cnt, 2);
    reset = 1'b0;
    #1;
    chk("abort_out", lane(0), 0);
    chk("abort_out_valid", out_valid, 0);
    chk("abort_busy", busy, 0);
    chk("abort_rd", ofifo_rd, 0);
    tick();
    reset = 1'b1;
    for (int c = 0; c < 6; c++) begin
      tick();
      chk("post_abort_valid", out_valid, 0);
      chk("post_abort_rd", ofifo_rd, 0);
    end
    ofifo_valid = 1'b0;
    tick();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
